// File: rtl/ula_seq_ctrl_pkg.sv
// Shared constants and types for the ALU operand-path micro-op sequencer.
package ula_seq_ctrl_pkg;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_NOT   = 4'd5;
  localparam logic [3:0] OP_INC   = 4'd6;
  localparam logic [3:0] OP_DEC   = 4'd7;
  localparam logic [3:0] OP_NEG   = 4'd8;
  localparam logic [3:0] OP_ABS   = 4'd9;
  localparam logic [3:0] OP_SETM1 = 4'd10;

  localparam logic [2:0] ULA_ADD   = 3'd0;
  localparam logic [2:0] ULA_SUB   = 3'd1;
  localparam logic [2:0] ULA_AND   = 3'd2;
  localparam logic [2:0] ULA_OR    = 3'd3;
  localparam logic [2:0] ULA_XOR   = 3'd4;
  localparam logic [2:0] ULA_NOT   = 3'd5;
  localparam logic [2:0] ULA_PASSA = 3'd6;

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_TMP = 2'd1;
  localparam logic [1:0] SEL_IMM = 2'd1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  // One step's worth of datapath controls; done also marks the final step.
  typedef struct packed {
    logic       ready;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       cmp2;
    logic       incdec;
    logic [2:0] ula_op;
    logic       tmp_we;
    logic       reg_we;
    logic       done;
    logic       err;
  } ctrl_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_SETM1;
  endfunction

endpackage

// File: rtl/ula_step_decode.sv
// Combinational map from (opcode, step, sign flag, immediate select) to the control word.
module ula_step_decode
  import ula_seq_ctrl_pkg::*;
(
  input  logic [3:0] opcode,
  input  state_t     state,
  input  logic       flag,
  input  logic       use_imm,
  output ctrl_t      ctrl
);

  always_comb begin
    // NOTE: every field gets a default first so no path through the case leaves a latch.
    ctrl = '0;
    unique case (state)
      ST_IDLE: ctrl.ready = 1'b1;
      ST_ERR:  ctrl.err   = 1'b1;
      ST_S1: begin
        unique case (opcode)
          OP_NEG: begin
            ctrl.ula_op = ULA_NOT;
            ctrl.tmp_we = 1'b1;
          end
          OP_ABS: begin
            ctrl.ula_op = ULA_PASSA;
            ctrl.tmp_we = 1'b1;
          end
          default: begin
            ctrl.sel_b  = use_imm ? SEL_IMM : SEL_REG;
            ctrl.reg_we = 1'b1;
            ctrl.done   = 1'b1;
            case (opcode)
              OP_SUB:   ctrl.ula_op = ULA_SUB;
              OP_AND:   ctrl.ula_op = ULA_AND;
              OP_OR:    ctrl.ula_op = ULA_OR;
              OP_XOR:   ctrl.ula_op = ULA_XOR;
              OP_NOT:   ctrl.ula_op = ULA_NOT;
              OP_INC:   ctrl.incdec = 1'b1;
              OP_DEC: begin
                ctrl.incdec = 1'b1;
                ctrl.ula_op = ULA_SUB;
              end
              OP_SETM1: begin
                ctrl.cmp2   = 1'b1;
                ctrl.ula_op = ULA_PASSA;
              end
              default:  ctrl.ula_op = ULA_ADD;
            endcase
          end
        endcase
      end
      ST_S2: begin
        ctrl.sel_a = SEL_TMP;
        if (opcode == OP_NEG) begin
          ctrl.incdec = 1'b1;
          ctrl.ula_op = ULA_ADD;
          ctrl.reg_we = 1'b1;
          ctrl.done   = 1'b1;
        end else if (flag) begin
          // Negative ABS operand: invert into TMP now, add one next step.
          ctrl.ula_op = ULA_NOT;
          ctrl.tmp_we = 1'b1;
        end else begin
          ctrl.ula_op = ULA_PASSA;
          ctrl.reg_we = 1'b1;
          ctrl.done   = 1'b1;
        end
      end
      ST_S3: begin
        ctrl.sel_a  = SEL_TMP;
        ctrl.incdec = 1'b1;
        ctrl.ula_op = ULA_ADD;
        ctrl.reg_we = 1'b1;
        ctrl.done   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ula_seq_ctrl.sv
// Micro-op sequencer for the ALU operand path: accepts one instruction and steps it for 1-3 cycles.
module ula_seq_ctrl
  import ula_seq_ctrl_pkg::*;
#(
  parameter int RADDR_W = 3,
  parameter int SEL_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               START,
  input  logic [3:0]         OPCODE,
  input  logic [RADDR_W-1:0] RD,
  input  logic               USE_IMM,
  input  logic               ULA_NEG,
  output logic               READY,
  output logic [SEL_W-1:0]   SEL_A,
  output logic [SEL_W-1:0]   SEL_B,
  output logic               CMP2,
  output logic               INCDEC,
  output logic [2:0]         ULA_OP,
  output logic               TMP_WE,
  output logic               REG_WE,
  output logic [RADDR_W-1:0] REG_WADDR,
  output logic               DONE,
  output logic               ERR
);

  state_t             state_q, state_d;
  logic [3:0]         op_q;
  logic [RADDR_W-1:0] rd_q;
  logic               imm_q;
  logic               flag_q;
  ctrl_t              ctrl;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      imm_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && START) begin
        op_q  <= OPCODE;
        rd_q  <= RD;
        imm_q <= USE_IMM;
      end
      if (state_q == ST_S1 && op_q == OP_ABS)
        flag_q <= ULA_NEG;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (START) state_d = is_legal(OPCODE) ? ST_S1 : ST_ERR;
      ST_S1:   state_d = ctrl.done ? ST_IDLE : ST_S2;
      ST_S2:   state_d = ctrl.done ? ST_IDLE : ST_S3;
      default: state_d = ST_IDLE;
    endcase
  end

  ula_step_decode u_decode (
    .opcode  (op_q),
    .state   (state_q),
    .flag    (flag_q),
    .use_imm (imm_q),
    .ctrl    (ctrl)
  );

  assign READY     = ctrl.ready;
  assign SEL_A     = SEL_W'(ctrl.sel_a);
  assign SEL_B     = SEL_W'(ctrl.sel_b);
  assign CMP2      = ctrl.cmp2;
  assign INCDEC    = ctrl.incdec;
  assign ULA_OP    = ctrl.ula_op;
  assign TMP_WE    = ctrl.tmp_we;
  assign REG_WE    = ctrl.reg_we;
  assign REG_WADDR = rd_q;
  assign DONE      = ctrl.done;
  assign ERR       = ctrl.err;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed, table-driven bench for ula_seq_ctrl plus hand-written reset sequences.
module tb_ula_seq_ctrl;

  typedef struct packed {
    logic       ready;
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic       cmp2;
    logic       incdec;
    logic [2:0] ula_op;
    logic       tmp_we;
    logic       reg_we;
    logic [2:0] waddr;
    logic       done;
    logic       err;
  } exp_t;

  typedef struct {
    string      name;
    logic       start;
    logic [3:0] op;
    logic [2:0] rd;
    logic       imm;
    logic       neg;
    exp_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       START;
  logic [3:0] OPCODE;
  logic [2:0] RD;
  logic       USE_IMM;
  logic       ULA_NEG;
  logic       READY;
  logic [3:0] SEL_A, SEL_B;
  logic       CMP2, INCDEC;
  logic [2:0] ULA_OP;
  logic       TMP_WE, REG_WE;
  logic [2:0] REG_WADDR;
  logic       DONE, ERR;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  ula_seq_ctrl #(.RADDR_W(3), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .START(START), .OPCODE(OPCODE), .RD(RD),
    .USE_IMM(USE_IMM), .ULA_NEG(ULA_NEG), .READY(READY), .SEL_A(SEL_A),
    .SEL_B(SEL_B), .CMP2(CMP2), .INCDEC(INCDEC), .ULA_OP(ULA_OP),
    .TMP_WE(TMP_WE), .REG_WE(REG_WE), .REG_WADDR(REG_WADDR), .DONE(DONE), .ERR(ERR)
  );

  always #5 clk = ~clk;

  function automatic exp_t ex(input logic rdy, input logic [3:0] sa, input logic [3:0] sb,
                              input logic c2, input logic id, input logic [2:0] op,
                              input logic twe, input logic rwe, input logic [2:0] wa,
                              input logic dn, input logic er);
    return exp_t'({rdy, sa, sb, c2, id, op, twe, rwe, wa, dn, er});
  endfunction

  function automatic exp_t obs();
    return exp_t'({READY, SEL_A, SEL_B, CMP2, INCDEC, ULA_OP, TMP_WE, REG_WE, REG_WADDR, DONE, ERR});
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %p required %p", name, got, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] op, input logic [2:0] rd,
                       input logic imm, input logic neg);
    START = s; OPCODE = op; RD = rd; USE_IMM = imm; ULA_NEG = neg;
  endtask

  task automatic add_vec(input string nm, input logic s, input logic [3:0] op,
                         input logic [2:0] rd, input logic imm, input logic neg, input exp_t e);
    vecs.push_back('{nm, s, op, rd, imm, neg, e});
  endtask

  initial begin
    // Inputs are applied just after an edge; the checked value is the state after the following edge.
    //       name           st op  rd imm neg   rdy sa sb c2 id op twe rwe wa dn er
    add_vec("add_imm",      1, 0,  5, 1, 0, ex(0, 0, 1, 0, 0, 0, 0, 1, 5, 1, 0));
    add_vec("add_idle",     0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0));
    add_vec("dec",          1, 7,  3, 0, 0, ex(0, 0, 0, 0, 1, 1, 0, 1, 3, 1, 0));
    add_vec("dec_idle",     0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
    add_vec("setm1",        1, 10, 1, 0, 0, ex(0, 0, 0, 1, 0, 6, 0, 1, 1, 1, 0));
    add_vec("setm1_idle",   0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add_vec("xor_reg",      1, 4,  6, 0, 0, ex(0, 0, 0, 0, 0, 4, 0, 1, 6, 1, 0));
    add_vec("xor_idle",     0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0));
    add_vec("sub_imm",      1, 1,  0, 1, 0, ex(0, 0, 1, 0, 0, 1, 0, 1, 0, 1, 0));
    add_vec("sub_idle",     0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_vec("neg_s1",       1, 8,  2, 0, 0, ex(0, 0, 0, 0, 0, 5, 1, 0, 2, 0, 0));
    add_vec("neg_s2_ign",   1, 0,  7, 1, 0, ex(0, 1, 0, 0, 1, 0, 0, 1, 2, 1, 0));
    add_vec("neg_idle",     0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    add_vec("neg_no_dup",   0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
    add_vec("abs_p_s1",     1, 9,  4, 0, 0, ex(0, 0, 0, 0, 0, 6, 1, 0, 4, 0, 0));
    add_vec("abs_p_s2",     0, 0,  0, 0, 0, ex(0, 1, 0, 0, 0, 6, 0, 1, 4, 1, 0));
    add_vec("abs_p_idle",   0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 4, 0, 0));
    add_vec("abs_n_s1",     1, 9,  7, 0, 0, ex(0, 0, 0, 0, 0, 6, 1, 0, 7, 0, 0));
    add_vec("abs_n_s2",     0, 0,  0, 0, 1, ex(0, 1, 0, 0, 0, 5, 1, 0, 7, 0, 0));
    add_vec("abs_n_s3",     0, 0,  0, 0, 0, ex(0, 1, 0, 0, 1, 0, 0, 1, 7, 1, 0));
    add_vec("abs_n_idle",   0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0));
    add_vec("ill_12",       1, 12, 3, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 1));
    add_vec("ill_12_idle",  0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
    add_vec("ill_15",       1, 15, 6, 0, 0, ex(0, 0, 0, 0, 0, 0, 0, 0, 6, 0, 1));
    add_vec("ill_15_idle",  0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 6, 0, 0));
    add_vec("inc_after",    1, 6,  5, 0, 0, ex(0, 0, 0, 0, 1, 0, 0, 1, 5, 1, 0));
    add_vec("inc_idle",     0, 0,  0, 0, 0, ex(1, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0));

    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    check("reset_state", obs(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("idle_%0d", i), obs(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].op, vecs[i].rd, vecs[i].imm, vecs[i].neg);
      tick();
      check(vecs[i].name, obs(), vecs[i].exp);
    end

    // Reset during ABS S2 (negative path) must abort with no write or DONE afterwards.
    drive(1, 9, 3, 0, 0);
    tick();
    check("mid_s1", obs(), ex(0, 0, 0, 0, 0, 6, 1, 0, 3, 0, 0));
    drive(0, 0, 0, 0, 1);
    tick();
    check("mid_s2", obs(), ex(0, 1, 0, 0, 0, 5, 1, 0, 3, 0, 0));
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    tick();
    check("mid_rst", obs(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_after_%0d", i), obs(), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ula_seq_ctrl.md
Name: ula_seq_ctrl

Overview:
- Micro-op sequencer for the ALU operand path: the two operand muxes, the cmp2 force-to-minus-one gate on A, and the incdec force-to-one gate on B.
- Accepts one ALU instruction through a START/READY handshake and drives operand selects, gate controls, ALU function code and write enables for 1–3 cycles.
- Multi-step ops (NEG, ABS) go through an internal temp register (TMP), which sits outside this block.
- Sits between instruction decode and the register-file/ALU datapath.

Parameters:
- RADDR_W, 3, register-file address width.
- SEL_W, 4, mux select width; matches the datapath muxes, which use only bits [1:0].

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- START  in  1  request; accepted only when READY=1.
- OPCODE  in  4  operation; sampled on accept.
- RD  in  RADDR_W  destination register; sampled on accept.
- USE_IMM  in  1  B operand comes from immediate; sampled on accept.
- ULA_NEG  in  1  ALU result sign flag; sampled in ABS step 1.
- READY  out  1  high only in IDLE.
- SEL_A  out  SEL_W  A-mux select: 0 = REG_OUT_A, 1 = TMP.
- SEL_B  out  SEL_W  B-mux select: 0 = REG_OUT_B, 1 = immediate.
- CMP2  out  1  drives the A gate; forces A to all ones.
- INCDEC  out  1  drives the B gate; forces B to 1.
- ULA_OP  out  3  ALU function code.
- TMP_WE  out  1  TMP load enable.
- REG_WE  out  1  register-file write enable.
- REG_WADDR  out  RADDR_W  write address; equals latched RD.
- DONE  out  1  one-cycle pulse in the final step of a legal op.
- ERR  out  1  one-cycle pulse for an illegal opcode.

Behaviour:
- Reset (rst=0 at a clock edge): state = IDLE.
  - READY=1; every other output = 0.
  - Latched opcode, RD, USE_IMM and the sign flag are cleared.
  - Reset mid-operation aborts the op; no REG_WE is issued after the reset edge.
- States: IDLE, S1, S2, S3, ERR. All outputs are decoded from registered state only; there is no combinational path from input to output.
- Accept: in IDLE with START=1, latch OPCODE, RD and USE_IMM, then go to S1 on the next cycle. START while READY=0 is ignored.
- Illegal opcode (11–15): go to ERR for one cycle. ERR=1, no write enables, then return to IDLE.
- Single-step ops: state S1 only; REG_WE=1 and DONE=1 in S1; SEL_A=0; SEL_B=USE_IMM.
  - 0 ADD: ULA_OP ADD.
  - 1 SUB: ULA_OP SUB.
  - 2 AND: ULA_OP AND.
  - 3 OR: ULA_OP OR.
  - 4 XOR: ULA_OP XOR.
  - 5 NOT: ULA_OP NOT.
  - 6 INC: INCDEC=1, ULA_OP ADD.
  - 7 DEC: INCDEC=1, ULA_OP SUB.
  - 10 SETM1: CMP2=1, ULA_OP PASSA.
- 8 NEG (2 cycles):
  - S1: SEL_A=0, ULA_OP NOT, TMP_WE=1.
  - S2: SEL_A=1, INCDEC=1, ULA_OP ADD, REG_WE=1, DONE=1.
- 9 ABS (2 or 3 cycles):
  - S1: SEL_A=0, ULA_OP PASSA, TMP_WE=1; register ULA_NEG into the sign flag.
  - S2 with flag=0: SEL_A=1, ULA_OP PASSA, REG_WE=1, DONE=1.
  - S2 with flag=1: SEL_A=1, ULA_OP NOT, TMP_WE=1.
  - S3: SEL_A=1, INCDEC=1, ULA_OP ADD, REG_WE=1, DONE=1.
- After the final step, return to IDLE; READY=1 the next cycle. Minimum issue interval is 2 cycles (accept cycle plus 1 step).
- REG_WE and TMP_WE are never high in the same cycle.
- CMP2 and INCDEC are never both high.
- Upper select bits [SEL_W-1:2] are always 0.

Decomposition:
- Shared package holds:
  - opcode constants OP_ADD..OP_SETM1;
  - ALU function codes: ULA_ADD=0, ULA_SUB=1, ULA_AND=2, ULA_OR=3, ULA_XOR=4, ULA_NOT=5, ULA_PASSA=6;
  - select constants SEL_REG=0, SEL_TMP=1, SEL_IMM=1;
  - state encoding.
- One sub-module, ula_step_decode: purely combinational map of (opcode, state, flag, USE_IMM) to the control word. The FSM and latches stay in ula_seq_ctrl.

Test Plan:
- Reset then idle: rst=0 for 2 cycles → READY=1, all other outputs 0; hold rst=1 with START=0 for 10 cycles → no REG_WE, no TMP_WE.
- ADD with immediate: START with OPCODE=0, RD=5, USE_IMM=1 → next cycle REG_WE=1, REG_WADDR=5, SEL_B=1, ULA_OP=0, DONE=1; READY=1 one cycle later. Repeat with OPCODE=7 → INCDEC=1, ULA_OP=1.
- NEG, RD=2: S1 shows TMP_WE=1, ULA_OP=5 → S2 shows SEL_A=1, INCDEC=1, ULA_OP=0, REG_WE=1, DONE=1. Exactly 2 busy cycles.
- ABS: with ULA_NEG=0 in S1 → write in S2, 2 busy cycles. With ULA_NEG=1 → S2 has TMP_WE=1 and ULA_OP=5; S3 has REG_WE=1, INCDEC=1. 3 busy cycles.
- Illegal and ignored requests: OPCODE=12 → ERR=1 for one cycle, REG_WE and DONE stay 0. START pulsed during a NEG S1 → ignored; only one DONE is produced.
- Reset mid-op: rst=0 during ABS S2 → next cycle IDLE, READY=1, REG_WE=0, and no DONE follows.
